// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between instruction fetch and data access.
// Data wins over fetch, fetch starvation is bounded, and hung responses time out.
module mem_arbiter #(
    parameter int unsigned DATA_STREAK = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_flush,
    output logic        fetch_done,
    output logic [31:0] fetch_rdata,
    input  logic        acc_req,
    input  logic [31:0] acc_addr,
    input  logic [31:0] acc_wdata,
    input  logic [3:0]  acc_wstrb,
    output logic        acc_done,
    output logic [31:0] acc_rdata,
    output logic        bus_err,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ACCESS
    } state_t;

    localparam int SW = $clog2(DATA_STREAK + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          flush_pending_q, flush_pending_d;
    logic          bubble_q, bubble_d;

    logic fetch_ok;
    logic flush_eff;
    logic grant_acc;
    logic grant_fetch;
    logic finish;
    logic timed_out;

    assign fetch_ok  = fetch_req && !fetch_flush;
    assign flush_eff = flush_pending_q || fetch_flush;

    always_comb begin
        state_d         = state_q;
        streak_d        = streak_q;
        tmo_d           = tmo_q;
        flush_pending_d = flush_pending_q;
        bubble_d        = 1'b0;
        grant_acc       = 1'b0;
        grant_fetch     = 1'b0;
        finish          = 1'b0;
        timed_out       = 1'b0;

        unique case (state_q)
            IDLE: begin
                tmo_d           = '0;
                flush_pending_d = 1'b0;
                if (!fetch_req) begin
                    streak_d = '0;
                end
                // The cycle right after a completion never grants, so a
                // requester still showing its old req is not served twice.
                if (!bubble_q) begin
                    if (acc_req && (streak_q < STREAK_MAX || !fetch_ok)) begin
                        grant_acc = 1'b1;
                        state_d   = ACCESS;
                        if (fetch_req && streak_q < STREAK_MAX) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else if (fetch_ok) begin
                        grant_fetch = 1'b1;
                        state_d     = FETCH;
                        streak_d    = '0;
                    end
                end
            end
            FETCH, ACCESS: begin
                tmo_d = tmo_q + 1'b1;
                if (state_q == FETCH && fetch_flush) begin
                    flush_pending_d = 1'b1;
                end
                if (mem_valid) begin
                    finish = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end
                if (finish) begin
                    state_d         = IDLE;
                    bubble_d        = 1'b1;
                    flush_pending_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            streak_q        <= '0;
            tmo_q           <= '0;
            flush_pending_q <= 1'b0;
            bubble_q        <= 1'b0;
            mem_ready       <= 1'b0;
            mem_instr       <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_wstrb       <= '0;
            fetch_done      <= 1'b0;
            fetch_rdata     <= '0;
            acc_done        <= 1'b0;
            acc_rdata       <= '0;
            bus_err         <= 1'b0;
        end else begin
            state_q         <= state_d;
            streak_q        <= streak_d;
            tmo_q           <= tmo_d;
            flush_pending_q <= flush_pending_d;
            bubble_q        <= bubble_d;
            fetch_done      <= 1'b0;
            acc_done        <= 1'b0;
            bus_err         <= 1'b0;

            if (grant_acc) begin
                mem_ready <= 1'b1;
                mem_instr <= 1'b0;
                mem_addr  <= acc_addr;
                mem_wdata <= acc_wdata;
                mem_wstrb <= acc_wstrb;
            end else if (grant_fetch) begin
                mem_ready <= 1'b1;
                mem_instr <= 1'b1;
                mem_addr  <= fetch_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end

            if (finish) begin
                mem_ready <= 1'b0;
                mem_instr <= 1'b0;
                if (state_q == ACCESS) begin
                    acc_done  <= 1'b1;
                    bus_err   <= timed_out;
                    acc_rdata <= timed_out ? '0 : mem_rdata;
                end else if (!flush_eff) begin
                    // A redirected fetch still drains on the bus but is never reported.
                    fetch_done  <= 1'b1;
                    bus_err     <= timed_out;
                    fetch_rdata <= timed_out ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int DS  = 4;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_flush;
    logic        fetch_done;
    logic [31:0] fetch_rdata;
    logic        acc_req;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic        acc_done;
    logic [31:0] acc_rdata;
    logic        bus_err;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    mem_arbiter #(
        .DATA_STREAK(DS),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_flush(fetch_flush),
        .fetch_done (fetch_done),
        .fetch_rdata(fetch_rdata),
        .acc_req    (acc_req),
        .acc_addr   (acc_addr),
        .acc_wdata  (acc_wdata),
        .acc_wstrb  (acc_wstrb),
        .acc_done   (acc_done),
        .acc_rdata  (acc_rdata),
        .bus_err    (bus_err),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: who owns the bus, for how long, and the data-run length
    int  m_owner   = 0;
    int  m_age     = 0;
    int  m_run     = 0;
    bit  m_cool    = 1'b0;
    bit  m_flushed = 1'b0;

    logic        e_ready = 1'b0;
    logic        e_instr = 1'b0;
    logic        e_fdone = 1'b0;
    logic        e_adone = 1'b0;
    logic        e_err   = 1'b0;
    logic [31:0] e_addr  = '0;
    logic [31:0] e_wdata = '0;
    logic [31:0] e_frd   = '0;
    logic [31:0] e_ard   = '0;
    logic [3:0]  e_wstrb = '0;

    bit mem_auto  = 1'b0;
    bit mem_rand  = 1'b0;
    int mem_fixed = 0;
    bit ag_busy   = 1'b0;
    int ag_cnt    = 0;
    int ag_dly    = 0;

    bit prev_ready = 1'b0;
    bit grants[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] data;
        bit          fok;
        if (reset) begin
            m_owner   = 0;
            m_age     = 0;
            m_run     = 0;
            m_cool    = 1'b0;
            m_flushed = 1'b0;
            e_ready   = 1'b0;
            e_instr   = 1'b0;
            e_fdone   = 1'b0;
            e_adone   = 1'b0;
            e_err     = 1'b0;
            e_addr    = '0;
            e_wdata   = '0;
            e_wstrb   = '0;
            e_frd     = '0;
            e_ard     = '0;
        end else begin
            e_fdone = 1'b0;
            e_adone = 1'b0;
            e_err   = 1'b0;
            if (m_owner != 0) begin
                if (m_owner == 1 && fetch_flush) m_flushed = 1'b1;
                if (mem_valid || m_age == TMO - 1) begin
                    data = mem_valid ? mem_rdata : 32'h0;
                    if (m_owner == 2) begin
                        e_adone = 1'b1;
                        e_ard   = data;
                        e_err   = !mem_valid;
                    end else if (!m_flushed) begin
                        e_fdone = 1'b1;
                        e_frd   = data;
                        e_err   = !mem_valid;
                    end
                    e_ready   = 1'b0;
                    e_instr   = 1'b0;
                    m_owner   = 0;
                    m_cool    = 1'b1;
                    m_flushed = 1'b0;
                end else begin
                    m_age++;
                end
            end else begin
                if (!fetch_req) m_run = 0;
                fok = fetch_req && !fetch_flush;
                if (m_cool) begin
                    m_cool = 1'b0;
                end else if (acc_req && (m_run < DS || !fok)) begin
                    m_owner = 2;
                    m_age   = 0;
                    e_ready = 1'b1;
                    e_instr = 1'b0;
                    e_addr  = acc_addr;
                    e_wdata = acc_wdata;
                    e_wstrb = acc_wstrb;
                    if (fetch_req && m_run < DS) m_run++;
                end else if (fok) begin
                    m_owner = 1;
                    m_age   = 0;
                    m_run   = 0;
                    e_ready = 1'b1;
                    e_instr = 1'b1;
                    e_addr  = fetch_addr;
                    e_wdata = '0;
                    e_wstrb = '0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("mem_ready", 32'(mem_ready), 32'(e_ready));
        check("mem_instr", 32'(mem_instr), 32'(e_instr));
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        check("fetch_done", 32'(fetch_done), 32'(e_fdone));
        check("fetch_rdata", fetch_rdata, e_frd);
        check("acc_done", 32'(acc_done), 32'(e_adone));
        check("acc_rdata", acc_rdata, e_ard);
        check("bus_err", 32'(bus_err), 32'(e_err));
        if (mem_ready && !prev_ready) grants.push_back(mem_instr);
        prev_ready = mem_ready;
    endtask

    task automatic drive_mem();
        if (mem_ready) begin
            if (!ag_busy) begin
                ag_busy = 1'b1;
                ag_cnt  = 0;
                ag_dly  = mem_rand ? $urandom_range(0, 9) : mem_fixed;
            end
            mem_valid = (ag_cnt == ag_dly);
            mem_rdata = $urandom;
            ag_cnt++;
        end else begin
            ag_busy   = 1'b0;
            mem_valid = mem_rand && ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
    endtask

    task automatic new_acc();
        acc_addr  = $urandom;
        acc_wdata = $urandom;
        acc_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    endtask

    task automatic drive_reqs();
        fetch_flush = 1'b0;
        if (fetch_req && fetch_done) begin
            fetch_req = 1'b0;
        end else if (!fetch_req) begin
            if ($urandom_range(0, 2) == 0) begin
                fetch_req  = 1'b1;
                fetch_addr = $urandom & 32'hFFFF_FFFC;
            end
        end else if ($urandom_range(0, 14) == 0) begin
            fetch_flush = 1'b1;
            fetch_addr  = $urandom & 32'hFFFF_FFFC;
        end
        if (acc_req && acc_done) begin
            acc_req = ($urandom_range(0, 1) == 1);
            new_acc();
        end else if (!acc_req && $urandom_range(0, 2) == 0) begin
            acc_req = 1'b1;
            new_acc();
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        fetch_req   = 1'b0;
        fetch_flush = 1'b0;
        acc_req     = 1'b0;
        mem_valid   = 1'b0;
        mem_auto    = 1'b0;
        mem_rand    = 1'b0;
        ag_busy     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        grants.delete();
    endtask

    task automatic step();
        if (mem_auto) drive_mem();
        tick();
    endtask

    initial begin
        int n;
        int gap;
        int hi;
        bit seen;

        fetch_addr = '0;
        acc_addr   = '0;
        acc_wdata  = '0;
        acc_wstrb  = '0;
        mem_rdata  = '0;
        do_reset();
        check("rst_ready", 32'(mem_ready), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_done", 32'({fetch_done, acc_done, bus_err}), 0);

        // plain fetch, response three cycles after the request
        fetch_req  = 1'b1;
        fetch_addr = 32'h100;
        tick();
        check("t1_ready", 32'(mem_ready), 1);
        check("t1_instr", 32'(mem_instr), 1);
        check("t1_addr", mem_addr, 32'h100);
        tick();
        tick();
        mem_valid = 1'b1;
        mem_rdata = 32'h13;
        tick();
        check("t1_drop", 32'(mem_ready), 0);
        check("t1_done", 32'(fetch_done), 1);
        check("t1_rdata", fetch_rdata, 32'h13);
        mem_valid = 1'b0;
        fetch_req = 1'b0;
        tick();
        check("t1_pulse", 32'(fetch_done), 0);

        // simultaneous requests: store goes first, fetch after the bubble
        do_reset();
        mem_auto   = 1'b1;
        mem_fixed  = 1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h104;
        acc_req    = 1'b1;
        acc_addr   = 32'h200;
        acc_wdata  = 32'hBEEF;
        acc_wstrb  = 4'b0011;
        step();
        check("t2_instr", 32'(mem_instr), 0);
        check("t2_wstrb", 32'(mem_wstrb), 32'h3);
        check("t2_addr", mem_addr, 32'h200);
        check("t2_wdata", mem_wdata, 32'hBEEF);
        n = 0;
        while (!acc_done && n < 20) begin
            step();
            n++;
        end
        check("t2_acc_done", 32'(acc_done), 1);
        acc_req = 1'b0;
        gap = 0;
        while (!mem_ready && gap < 20) begin
            step();
            gap++;
        end
        check("t2_gap", gap, 2);
        check("t2_f_instr", 32'(mem_instr), 1);
        check("t2_f_addr", mem_addr, 32'h104);
        n = 0;
        while (!fetch_done && n < 20) begin
            step();
            n++;
        end
        check("t2_f_done", 32'(fetch_done), 1);
        fetch_req = 1'b0;
        step();

        // data streak bound: four data grants then one fetch
        do_reset();
        mem_auto   = 1'b1;
        mem_fixed  = 0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h180;
        acc_req    = 1'b1;
        acc_addr   = 32'h280;
        acc_wstrb  = 4'h0;
        n = 0;
        while (grants.size() < 10 && n < 300) begin
            step();
            n++;
        end
        check("t3_count", 32'(grants.size() >= 10), 1);
        for (int i = 0; i < 10 && i < grants.size(); i++) begin
            check("t3_grant", 32'(grants[i]), 32'((i % 5) == 4));
        end
        fetch_req = 1'b0;
        acc_req   = 1'b0;

        // redirect while a fetch is in flight
        do_reset();
        mem_auto   = 1'b1;
        mem_fixed  = 3;
        fetch_req  = 1'b1;
        fetch_addr = 32'h80;
        step();
        check("t4_grant", 32'(mem_instr), 1);
        fetch_flush = 1'b1;
        fetch_addr  = 32'h40;
        step();
        fetch_flush = 1'b0;
        seen = 1'b0;
        n = 0;
        while (mem_ready && n < 20) begin
            step();
            seen |= fetch_done;
            n++;
        end
        check("t4_no_done", 32'(seen), 0);
        n = grants.size();
        gap = 0;
        while (grants.size() == n && gap < 20) begin
            step();
            gap++;
        end
        check("t4_addr", mem_addr, 32'h40);
        check("t4_instr", 32'(mem_instr), 1);
        n = 0;
        while (!fetch_done && n < 20) begin
            step();
            n++;
        end
        check("t4_done", 32'(fetch_done), 1);
        fetch_req = 1'b0;
        step();

        // response timeout on a load
        mem_auto  = 1'b0;
        mem_valid = 1'b0;
        acc_req   = 1'b1;
        acc_addr  = 32'h300;
        acc_wstrb = 4'h0;
        tick();
        hi = 0;
        n = 0;
        while (!acc_done && n < 40) begin
            if (mem_ready) hi++;
            tick();
            n++;
        end
        check("t5_ready_cyc", hi, TMO);
        check("t5_done", 32'(acc_done), 1);
        check("t5_err", 32'(bus_err), 1);
        check("t5_rdata", acc_rdata, 0);
        acc_req = 1'b0;
        tick();
        check("t5_err_pulse", 32'(bus_err), 0);

        // reset in the middle of an access, then a late response
        do_reset();
        acc_req   = 1'b1;
        acc_addr  = 32'h400;
        acc_wdata = 32'h1234_5678;
        acc_wstrb = 4'hF;
        tick();
        check("t6_grant", 32'(mem_ready), 1);
        tick();
        reset = 1'b1;
        tick();
        check("t6_ready", 32'(mem_ready), 0);
        reset     = 1'b0;
        acc_req   = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 32'h55;
        tick();
        check("t6_no_done", 32'(acc_done), 0);
        check("t6_no_ready", 32'(mem_ready), 0);
        mem_valid  = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h10;
        tick();
        check("t6_idle", 32'(mem_ready && mem_instr), 1);
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        fetch_req = 1'b0;
        tick();

        // randomized traffic with occasional resets and stray responses
        do_reset();
        mem_auto = 1'b1;
        mem_rand = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            drive_reqs();
            step();
        end
        reset     = 1'b0;
        fetch_req = 1'b0;
        acc_req   = 1'b0;
        mem_rand  = 1'b0;
        for (int c = 0; c < 20; c++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
